bitrev_reorder_buffer: RTL

Ping-pong frame buffer at the output of the streaming FFT pipeline. It accepts FFT results in bit-reversed index order and emits them in natural order. Two frame banks allow one frame to be written while the previous one is read. Valid/ready handshakes on both sides let it absorb backpressure from downstream consumers.

---
 rtl/bitrev_reorder_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bitrev_reorder_buffer.sv
// Ping-pong frame buffer: accepts FFT samples in bit-reversed order and emits them in natural order.
// Optional out_last port is enabled with `define REORDER_LAST_EN.
module bitrev_reorder_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_LOG2     = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef REORDER_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int N = 1 << N_LOG2;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = a[N_LOG2-1-i];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [0:1][0:N-1];

  logic                  wr_bank_q, wr_bank_d;
  logic [N_LOG2-1:0]     wr_cnt_q, wr_cnt_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [N_LOG2-1:0]     rd_cnt_q, rd_cnt_d;
  logic [1:0]            full_q, full_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic wr_fire;
  logic rd_load;
  logic wr_last;
  logic rd_last;

  // in_ready depends on registers only, so there is no in_valid -> in_ready path.
  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign rd_load  = full_q[rd_bank_q] && (!out_valid_q || out_ready);
  assign wr_last  = &wr_cnt_q;
  assign rd_last  = &rd_cnt_q;

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    // The bank is released when its last word enters the output register,
    // not when downstream takes it; wr_bank and rd_bank never hit the same bank here.
    if (rd_load) begin
      out_data_d  = mem_q[rd_bank_q][rd_cnt_q];
      out_valid_d = 1'b1;
      rd_cnt_d    = rd_cnt_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Sample storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_fire && !clr) begin
      mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef REORDER_LAST_EN
  logic out_last_q, out_last_d;

  always_comb begin
    out_last_d = out_last_q;
    if (rd_load) begin
      out_last_d = rd_last;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out_last_q <= 1'b0;
    end else begin
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

endmodule
